// File: rtl/jenkins_keyfeed.sv
// rtl/jenkins_keyfeed.sv - key-to-byte-stream driver for a one-at-a-time hasher
module jenkins_keyfeed #(
  parameter int MAX_BYTES = 8,
  parameter int LEN_W     = 4,
  parameter int TIMEOUT   = 15
) (
  input  logic                   CLOCK,
  input  logic                   RESET_N,
  input  logic [8*MAX_BYTES-1:0] key_in,
  input  logic [LEN_W-1:0]       key_len,
  input  logic                   key_valid,
  output logic                   key_ready,
  output logic                   sample,
  output logic [7:0]             value,
  input  logic                   complete,
  input  logic [31:0]            hash,
  output logic [31:0]            hash_out,
  output logic                   hash_err,
  output logic                   hash_valid,
  input  logic                   hash_ready
);

  localparam int                TOUT_W    = $clog2(TIMEOUT) + 1;
  localparam logic [LEN_W-1:0]  MAX_LEN   = LEN_W'(MAX_BYTES);
  localparam logic [TOUT_W-1:0] TOUT_LAST = TOUT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FEED,
    S_WAIT,
    S_RESULT
  } state_t;

  state_t                 state_q, state_d;
  logic [1:0]             guard_q;
  logic [LEN_W-1:0]       idx_q, idx_d;
  logic [LEN_W-1:0]       n_q, n_d;
  logic [LEN_W-1:0]       len_clamped;
  logic [8*MAX_BYTES-1:0] key_q, key_d;
  logic [TOUT_W-1:0]      tout_q, tout_d;
  logic                   sample_d;
  logic [7:0]             value_d;
  logic [31:0]            hash_out_d;
  logic                   hash_err_d;
  logic                   hash_valid_d;
  logic                   key_fire;

  // Keys are only taken in IDLE once the post-reset flush window is over.
  assign key_ready = (state_q == S_IDLE) && (guard_q == 2'd0);
  assign key_fire  = key_valid && key_ready;

  // Post-reset guard: gives a hasher abandoned mid-key two quiet cycles to
  // emit its stray complete and clear its work register.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      guard_q <= 2'd2;
    end else if (guard_q != 2'd0) begin
      guard_q <= guard_q - 2'd1;
    end
  end

  // Next-state and datapath: the key is held in a shift register so the
  // next byte to send is always in the low 8 bits.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    n_d          = n_q;
    key_d        = key_q;
    tout_d       = tout_q;
    sample_d     = sample;
    value_d      = value;
    hash_out_d   = hash_out;
    hash_err_d   = hash_err;
    hash_valid_d = hash_valid;
    len_clamped  = (key_len > MAX_LEN) ? MAX_LEN : key_len;

    case (state_q)
      S_IDLE: begin
        if (key_fire) begin
          n_d = len_clamped;
          if (len_clamped == '0) begin
            // Empty key: report the zero hash without touching the hasher.
            hash_out_d   = 32'd0;
            hash_err_d   = 1'b0;
            hash_valid_d = 1'b1;
            state_d      = S_RESULT;
          end else begin
            sample_d = 1'b1;
            value_d  = key_in[7:0];
            key_d    = key_in >> 8;
            idx_d    = LEN_W'(1);
            state_d  = S_FEED;
          end
        end
      end

      S_FEED: begin
        if (idx_q < n_q) begin
          value_d = key_q[7:0];
          key_d   = key_q >> 8;
          idx_d   = idx_q + LEN_W'(1);
        end else begin
          sample_d = 1'b0;
          value_d  = 8'd0;
          tout_d   = '0;
          state_d  = S_WAIT;
        end
      end

      S_WAIT: begin
        if (complete) begin
          hash_out_d   = hash;
          hash_err_d   = 1'b0;
          hash_valid_d = 1'b1;
          state_d      = S_RESULT;
        end else if (tout_q == TOUT_LAST) begin
          hash_out_d   = 32'd0;
          hash_err_d   = 1'b1;
          hash_valid_d = 1'b1;
          state_d      = S_RESULT;
        end else begin
          tout_d = tout_q + TOUT_W'(1);
        end
      end

      S_RESULT: begin
        if (hash_ready) begin
          hash_valid_d = 1'b0;
          hash_err_d   = 1'b0;
          state_d      = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered hasher/result outputs; reset abandons any key.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      n_q        <= '0;
      key_q      <= '0;
      tout_q     <= '0;
      sample     <= 1'b0;
      value      <= 8'd0;
      hash_out   <= 32'd0;
      hash_err   <= 1'b0;
      hash_valid <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      n_q        <= n_d;
      key_q      <= key_d;
      tout_q     <= tout_d;
      sample     <= sample_d;
      value      <= value_d;
      hash_out   <= hash_out_d;
      hash_err   <= hash_err_d;
      hash_valid <= hash_valid_d;
    end
  end

endmodule

// File: tb/tb_jenkins_keyfeed.sv
// tb/tb_jenkins_keyfeed.sv - directed bench for jenkins_keyfeed with a hasher model
module tb_jenkins_keyfeed;

  logic        CLOCK = 1'b0;
  logic        RESET_N;
  logic [63:0] key_in;
  logic [3:0]  key_len;
  logic        key_valid;
  logic        key_ready;
  logic        sample;
  logic [7:0]  value;
  logic        complete = 1'b0;
  logic [31:0] hash = 32'd0;
  logic [31:0] hash_out;
  logic        hash_err;
  logic        hash_valid;
  logic        hash_ready;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  got[$];
  int          value_bad;
  logic        mute = 1'b0;
  logic [31:0] hw = 32'd0;
  logic        prev_s = 1'b0;

  jenkins_keyfeed #(.MAX_BYTES(8), .LEN_W(4), .TIMEOUT(15)) dut (
    .CLOCK      (CLOCK),
    .RESET_N    (RESET_N),
    .key_in     (key_in),
    .key_len    (key_len),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .sample     (sample),
    .value      (value),
    .complete   (complete),
    .hash       (hash),
    .hash_out   (hash_out),
    .hash_err   (hash_err),
    .hash_valid (hash_valid),
    .hash_ready (hash_ready)
  );

  always #5 CLOCK = ~CLOCK;

  function automatic logic [31:0] oaat_mix(input logic [31:0] h, input logic [7:0] b);
    logic [31:0] t;
    t = h + {24'd0, b};
    t = t + (t << 10);
    t = t ^ (t >> 6);
    return t;
  endfunction

  function automatic logic [31:0] oaat_fin(input logic [31:0] h);
    logic [31:0] t;
    t = h + (h << 3);
    t = t ^ (t >> 11);
    t = t + (t << 15);
    return t;
  endfunction

  function automatic logic [31:0] oaat_ref(input logic [63:0] k, input int n);
    logic [31:0] h;
    h = 32'd0;
    for (int i = 0; i < n; i++) h = oaat_mix(h, k[8*i +: 8]);
    return oaat_fin(h);
  endfunction

  // Byte-serial hasher: finalises on the first low sample after a burst and
  // pulses complete one cycle later; never reset, like a separate block.
  always @(posedge CLOCK) begin
    prev_s   <= sample;
    complete <= 1'b0;
    if (sample) begin
      hw <= oaat_mix(hw, value);
    end else if (prev_s) begin
      complete <= !mute;
      hash     <= oaat_fin(hw);
      hw       <= 32'd0;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLOCK);
    #1;
  endtask

  task automatic run_key(input logic [63:0] k, input logic [3:0] len, input int budget,
                         output int lat);
    int waited;
    waited = 0;
    while (!key_ready && waited < 50) begin
      tick;
      waited++;
    end
    check_eq("key_ready_wait", key_ready, 1);
    got.delete();
    value_bad = 0;
    lat = -1;
    key_in    = k;
    key_len   = len;
    key_valid = 1'b1;
    tick;
    key_valid = 1'b0;
    key_in    = 64'hDEAD_BEEF_CAFE_F00D;
    key_len   = 4'd3;
    for (int c = 0; c <= budget; c++) begin
      if (hash_valid) begin
        lat = c;
        break;
      end
      if (sample) got.push_back(value);
      else if (value != 8'd0) value_bad++;
      tick;
    end
  endtask

  function automatic logic [63:0] got_packed();
    logic [63:0] p;
    p = 64'd0;
    for (int i = 0; i < got.size() && i < 8; i++) p[8*i +: 8] = got[i];
    return p;
  endfunction

  task automatic accept_result;
    hash_ready = 1'b1;
    tick;
    hash_ready = 1'b0;
    check_eq("accept_clears_valid", hash_valid, 0);
    check_eq("accept_ready_again", key_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [31:0] h1;
    logic [31:0] hv_o;
    logic        he_o;
    int          bad;

    RESET_N    = 1'b0;
    key_in     = 64'd0;
    key_len    = 4'd0;
    key_valid  = 1'b0;
    hash_ready = 1'b0;
    repeat (3) tick;

    check_eq("rst_sample", sample, 0);
    check_eq("rst_value", value, 0);
    check_eq("rst_hash_out", hash_out, 0);
    check_eq("rst_hash_err", hash_err, 0);
    check_eq("rst_hash_valid", hash_valid, 0);
    check_eq("rst_key_ready", key_ready, 0);
    RESET_N = 1'b1;
    check_eq("guard_0", key_ready, 0);
    tick;
    check_eq("guard_1", key_ready, 0);
    tick;
    check_eq("guard_2", key_ready, 1);

    // Key "a"
    run_key(64'h61, 4'd1, 40, lat);
    check_eq("a_lat", lat, 3);
    check_eq("a_nbytes", got.size(), 1);
    check_eq("a_bytes", got_packed(), 64'h61);
    check_eq("a_hash", hash_out, 32'hCA2E9442);
    check_eq("a_err", hash_err, 0);
    check_eq("a_idle_value", value_bad, 0);
    accept_result();

    // Empty key
    run_key(64'h1234, 4'd0, 40, lat);
    check_eq("empty_lat", lat, 0);
    check_eq("empty_nbytes", got.size(), 0);
    check_eq("empty_hash", hash_out, 0);
    check_eq("empty_err", hash_err, 0);
    accept_result();

    // "abc", then the same key back-to-back with hash_ready held high
    run_key(64'h636261, 4'd3, 40, lat);
    check_eq("abc_lat", lat, 5);
    check_eq("abc_nbytes", got.size(), 3);
    check_eq("abc_bytes", got_packed(), 64'h636261);
    check_eq("abc_hash", hash_out, oaat_ref(64'h636261, 3));
    h1 = hash_out;
    hash_ready = 1'b1;
    run_key(64'h636261, 4'd3, 40, lat);
    check_eq("abc2_lat", lat, 5);
    check_eq("abc2_bytes", got_packed(), 64'h636261);
    check_eq("abc2_hash", hash_out, h1);
    tick;
    hash_ready = 1'b0;
    check_eq("abc2_auto_accept", hash_valid, 0);

    // Over-long key length clamps to 8 bytes
    run_key(64'h8877665544332211, 4'd12, 40, lat);
    check_eq("clamp_lat", lat, 10);
    check_eq("clamp_nbytes", got.size(), 8);
    check_eq("clamp_bytes", got_packed(), 64'h8877665544332211);
    check_eq("clamp_hash", hash_out, oaat_ref(64'h8877665544332211, 8));
    check_eq("clamp_idle_value", value_bad, 0);
    accept_result();

    // Hasher that never completes
    mute = 1'b1;
    run_key(64'h61, 4'd1, 40, lat);
    check_eq("tout_lat", lat, 16);
    check_eq("tout_err", hash_err, 1);
    check_eq("tout_hash", hash_out, 0);
    hv_o = hash_out;
    he_o = hash_err;
    bad  = 0;
    for (int i = 0; i < 5; i++) begin
      tick;
      if (!hash_valid || hash_out != hv_o || hash_err != he_o || key_ready) bad++;
    end
    check_eq("tout_hold", bad, 0);
    accept_result();
    check_eq("tout_err_cleared", hash_err, 0);
    mute = 1'b0;

    // Reset in the middle of a 5-byte key
    key_in    = 64'h6867666564;
    key_len   = 4'd5;
    key_valid = 1'b1;
    tick;
    key_valid = 1'b0;
    tick;
    tick;
    check_eq("mid_sample_high", sample, 1);
    RESET_N = 1'b0;
    #1;
    check_eq("mid_rst_sample", sample, 0);
    check_eq("mid_rst_value", value, 0);
    check_eq("mid_rst_valid", hash_valid, 0);
    #2;
    RESET_N = 1'b1;
    check_eq("mid_guard_0", key_ready, 0);
    tick;
    check_eq("mid_guard_1", key_ready, 0);
    tick;
    check_eq("mid_guard_2", key_ready, 1);
    check_eq("mid_stray_ignored", hash_valid, 0);
    run_key(64'h61, 4'd1, 40, lat);
    check_eq("post_rst_lat", lat, 3);
    check_eq("post_rst_hash", hash_out, 32'hCA2E9442);
    accept_result();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
